// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS data RAM block.
package mips_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam logic [31:0] DEF_ADDR_BASE   = 32'h0000_1000;
  localparam int          DEF_DEPTH_WORDS = 256;

endpackage

// File: rtl/mips_mem_addr_decode.sv
// Maps a CPU byte address onto a word index plus an in-window/aligned flag.
module mips_mem_addr_decode
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic [31:0]   data_address,
  output logic [AW-1:0] index,
  output logic          valid
);

  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  // 33-bit difference: an address below the base borrows into bit 32,
  // which pushes it past SPAN, so one compare covers both window edges.
  logic [32:0] diff;

  assign diff  = {1'b0, data_address} - {1'b0, ADDR_BASE};
  assign valid = (data_address[1:0] == 2'b00) && (diff < SPAN);
  assign index = diff[AW+1:2];

endmodule

// File: rtl/mips_data_ram.sv
// Word-addressed data RAM for a MIPS core: self-clears after reset, then
// serves zero-latency loads and single-cycle stores with error/count status.
module mips_data_ram
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        ready,
  output logic        access_error,
  output logic [15:0] write_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_e    state_q, state_d;
  logic [AW-1:0] clr_ptr;
  logic [AW-1:0] idx;
  logic          addr_ok;
  logic [15:0]   wr_cnt;
  logic          err_q;
  logic          in_ready, access, commit, clr_last;
  logic [31:0]   mem [DEPTH_WORDS];

  mips_mem_addr_decode #(
    .ADDR_BASE   (ADDR_BASE),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_decode (
    .data_address (data_address),
    .index        (idx),
    .valid        (addr_ok)
  );

  assign in_ready = (state_q == READY);
  assign access   = in_ready && (data_read || data_write);
  assign commit   = in_ready && clk_enable && data_write && addr_ok;
  assign clr_last = (clr_ptr == AW'(DEPTH_WORDS - 1));

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clk_enable && clr_last) state_d = READY;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= CLEAR;
      clr_ptr <= '0;
      wr_cnt  <= '0;
      err_q   <= 1'b0;
    end else if (clk_enable) begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (commit && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      if (access && !addr_ok) err_q <= 1'b1;
    end
  end

  // No reset on the array so it maps onto RAM; zeroing is done by CLEAR.
  always_ff @(posedge clk) begin
    if (reset && clk_enable) begin
      if (state_q == CLEAR) mem[clr_ptr] <= '0;
      else if (commit)      mem[idx]     <= data_writedata;
    end
  end

  // Combinational read sees the pre-edge contents: read-before-write.
  assign data_readdata = (in_ready && data_read && addr_ok) ? mem[idx] : 32'h0;
  assign ready         = in_ready;
  assign access_error  = err_q;
  assign write_count   = wr_cnt;

endmodule
